// File: rtl/cache_2way_ctrl_if.sv
// User-side request/response and backing-memory handshake bundle for cache_2way_ctrl.
// The controller attaches to the slave modport; the environment drives the master side.
interface cache_2way_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();
  logic              cpu_req;
  logic              cpu_wren;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_done;
  logic              cpu_hit;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_req;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_wren, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_ready, cpu_done, cpu_hit, cpu_rdata, mem_req, mem_wren, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_wren, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_ready, cpu_done, cpu_hit, cpu_rdata, mem_req, mem_wren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_2way_ctrl.sv
// 2-way set-associative write-back/write-allocate cache controller, LRU replacement.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_2way_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SETS   = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  cache_2way_ctrl_if.slave  bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND} state_t;

  state_t state, next_state;

  // Tag/data storage is never reset; only the valid bits qualify it.
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS];
  logic [1:0][SETS-1:0] valid_q;
  logic [1:0][SETS-1:0] dirty_q;
  logic [SETS-1:0]      lru_q;    // way to evict next in each set
  logic                 victim_q;

  logic [ADDR_W-1:0] req_addr;
  logic              req_wren;
  logic [DATA_W-1:0] req_wdata;

  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               hit0, hit1, hit, hit_way;
  logic               victim_sel, victim_dirty;
  logic               mem_fire;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign req_idx = req_addr[INDEX_W-1:0];
  assign req_tag = req_addr[ADDR_W-1:INDEX_W];

  assign bus.cpu_ready = (state == IDLE);
  assign mem_fire      = bus.mem_req & bus.mem_ack;

  always_comb begin
    hit0         = valid_q[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    hit1         = valid_q[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    hit          = hit0 | hit1;
    hit_way      = hit1;
    victim_sel   = !valid_q[0][req_idx] ? 1'b0 :
                   !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    victim_dirty = valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (bus.cpu_req) next_state = LOOKUP;
      LOOKUP:    next_state = hit ? IDLE : (victim_dirty ? WRITEBACK : FILL);
      WRITEBACK: if (mem_fire) next_state = FILL;
      FILL:      if (mem_fire) next_state = RESPOND;
      RESPOND:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Request capture and line storage (no reset).
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.cpu_req) begin
      req_addr  <= bus.cpu_addr;
      req_wren  <= bus.cpu_wren;
      req_wdata <= bus.cpu_wdata;
    end
    if (state == LOOKUP && hit && req_wren)
      data_mem[hit_way][req_idx] <= req_wdata;
    if (state == FILL && mem_fire) begin
      data_mem[victim_q][req_idx] <= bus.mem_rdata;
      tag_mem[victim_q][req_idx]  <= req_tag;
    end
    if (state == RESPOND && req_wren)
      data_mem[victim_q][req_idx] <= req_wdata;
  end

  // Line status, memory handshake and user response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= '0;
      dirty_q       <= '0;
      lru_q         <= '0;
      victim_q      <= 1'b0;
      bus.cpu_done  <= 1'b0;
      bus.cpu_hit   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_wren  <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef CACHE_STATS_EN
      hit_count     <= '0;
      miss_count    <= '0;
`endif
    end else begin
      bus.cpu_done <= 1'b0;
      case (state)
        LOOKUP: begin
          if (hit) begin
            if (req_wren) dirty_q[hit_way][req_idx] <= 1'b1;
            lru_q[req_idx] <= ~hit_way;
            bus.cpu_done   <= 1'b1;
            bus.cpu_hit    <= 1'b1;
            bus.cpu_rdata  <= req_wren ? req_wdata : data_mem[hit_way][req_idx];
`ifdef CACHE_STATS_EN
            hit_count      <= sat_inc(hit_count);
`endif
          end else begin
            victim_q    <= victim_sel;
            bus.mem_req <= 1'b1;
            if (victim_dirty) begin
              bus.mem_wren  <= 1'b1;
              bus.mem_addr  <= {tag_mem[victim_sel][req_idx], req_idx};
              bus.mem_wdata <= data_mem[victim_sel][req_idx];
            end else begin
              bus.mem_wren <= 1'b0;
              bus.mem_addr <= req_addr;
            end
          end
        end
        WRITEBACK: begin
          // Drop the request for one cycle so the fill is a distinct transaction.
          if (mem_fire) begin
            bus.mem_req  <= 1'b0;
            bus.mem_wren <= 1'b0;
            bus.mem_addr <= req_addr;
          end
        end
        FILL: begin
          if (mem_fire) begin
            bus.mem_req                <= 1'b0;
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
          end else begin
            bus.mem_req <= 1'b1;
          end
        end
        RESPOND: begin
          if (req_wren) dirty_q[victim_q][req_idx] <= 1'b1;
          lru_q[req_idx] <= ~victim_q;
          bus.cpu_done   <= 1'b1;
          bus.cpu_hit    <= 1'b0;
          bus.cpu_rdata  <= req_wren ? req_wdata : data_mem[victim_q][req_idx];
`ifdef CACHE_STATS_EN
          miss_count     <= sat_inc(miss_count);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_2way_ctrl.sv
// Directed bench for cache_2way_ctrl (ADDR_W=8, DATA_W=8, SETS=4) with a hand-driven backing memory.
// Statistics checks are included when CACHE_STATS_EN is defined.
module tb_cache_2way_ctrl;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  cache_2way_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_2way_ctrl #(.ADDR_W(8), .DATA_W(8), .SETS(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic drive_req(input logic [7:0] a, input logic w, input logic [7:0] d);
    @(negedge clock);
    bus.cpu_req   = 1'b1;
    bus.cpu_wren  = w;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    @(negedge clock);
    bus.cpu_req   = 1'b0;
  endtask

  task automatic wait_mem(output logic seen);
    int cyc;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 50) begin
      if (bus.mem_req) seen = 1'b1;
      else begin
        @(negedge clock);
        cyc++;
      end
    end
  endtask

  task automatic mem_ack_now(input logic [7:0] d);
    bus.mem_rdata = d;
    bus.mem_ack   = 1'b1;
    @(negedge clock);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
  endtask

  task automatic wait_done(output logic seen, output int edges, output logic hit,
                           output logic [7:0] rd, output logic saw_mem);
    seen = 1'b0; edges = 1; hit = 1'b0; rd = 8'h00; saw_mem = 1'b0;
    while (!seen && edges < 60) begin
      if (bus.mem_req) saw_mem = 1'b1;
      if (bus.cpu_done) begin
        seen = 1'b1;
        hit  = bus.cpu_hit;
        rd   = bus.cpu_rdata;
      end else begin
        @(negedge clock);
        edges++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_vec++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_done !== 1'b0 || bus.cpu_hit !== 1'b0 ||
        bus.cpu_rdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_cpu: ready=%b done=%b hit=%b rdata=%h expected 1 0 0 00",
               bus.cpu_ready, bus.cpu_done, bus.cpu_hit, bus.cpu_rdata);
    end
    n_vec++;
    if (bus.mem_req !== 1'b0 || bus.mem_wren !== 1'b0 || bus.mem_addr !== 8'h00 ||
        bus.mem_wdata !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mem: req=%b wren=%b addr=%h wdata=%h expected 0 0 00 00",
               bus.mem_req, bus.mem_wren, bus.mem_addr, bus.mem_wdata);
    end
`ifdef CACHE_STATS_EN
    n_vec++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_stats: hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
    end
`endif
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read_miss_fill();
    logic seen, hit, saw_mem;
    logic [7:0] rd;
    int edges;
    drive_req(8'h05, 1'b0, 8'h00);
    wait_mem(seen);
    n_vec++;
    if (!seen || bus.mem_wren !== 1'b0 || bus.mem_addr !== 8'h05) begin
      n_err++;
      $display("FAIL miss_fill_req: seen=%b wren=%b addr=%h expected 1 0 05", seen, bus.mem_wren, bus.mem_addr);
    end
    mem_ack_now(8'h3C);
    n_vec++;
    if (bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL miss_req_drop: mem_req=%b expected 0", bus.mem_req);
    end
    wait_done(seen, edges, hit, rd, saw_mem);
    n_vec++;
    if (!seen || hit !== 1'b0 || rd !== 8'h3C) begin
      n_err++;
      $display("FAIL miss_done: seen=%b hit=%b rdata=%h expected 1 0 3c", seen, hit, rd);
    end
  endtask

  task automatic test_read_hit();
    logic seen, hit, saw_mem;
    logic [7:0] rd;
    int edges;
    drive_req(8'h05, 1'b0, 8'h00);
    wait_done(seen, edges, hit, rd, saw_mem);
    n_vec++;
    if (!seen || hit !== 1'b1 || rd !== 8'h3C || saw_mem !== 1'b0) begin
      n_err++;
      $display("FAIL hit_read: seen=%b hit=%b rdata=%h mem=%b expected 1 1 3c 0", seen, hit, rd, saw_mem);
    end
    n_vec++;
    if (edges !== 2) begin
      n_err++;
      $display("FAIL hit_latency: done after %0d edges expected 2", edges);
    end
  endtask

  task automatic test_write_hit();
    logic seen, hit, saw_mem;
    logic [7:0] rd;
    int edges;
    drive_req(8'h05, 1'b1, 8'hA7);
    wait_done(seen, edges, hit, rd, saw_mem);
    n_vec++;
    if (!seen || hit !== 1'b1 || saw_mem !== 1'b0) begin
      n_err++;
      $display("FAIL write_hit: seen=%b hit=%b mem=%b expected 1 1 0", seen, hit, saw_mem);
    end
    // A stray ack while idle must not disturb anything.
    @(negedge clock);
    mem_ack_now(8'hFF);
    drive_req(8'h05, 1'b0, 8'h00);
    wait_done(seen, edges, hit, rd, saw_mem);
    n_vec++;
    if (!seen || hit !== 1'b1 || rd !== 8'hA7 || saw_mem !== 1'b0) begin
      n_err++;
      $display("FAIL read_after_write: seen=%b hit=%b rdata=%h mem=%b expected 1 1 a7 0", seen, hit, rd, saw_mem);
    end
  endtask

  task automatic test_writeback();
    logic seen, hit, saw_mem;
    logic [7:0] rd;
    int edges;
    drive_req(8'h09, 1'b0, 8'h00);
    wait_mem(seen);
    n_vec++;
    if (!seen || bus.mem_wren !== 1'b0 || bus.mem_addr !== 8'h09) begin
      n_err++;
      $display("FAIL fill_09: seen=%b wren=%b addr=%h expected 1 0 09", seen, bus.mem_wren, bus.mem_addr);
    end
    mem_ack_now(8'h51);
    wait_done(seen, edges, hit, rd, saw_mem);
    n_vec++;
    if (!seen || hit !== 1'b0 || rd !== 8'h51) begin
      n_err++;
      $display("FAIL done_09: seen=%b hit=%b rdata=%h expected 1 0 51", seen, hit, rd);
    end
    drive_req(8'h0D, 1'b0, 8'h00);
    wait_mem(seen);
    n_vec++;
    if (!seen || bus.mem_wren !== 1'b1 || bus.mem_addr !== 8'h05 || bus.mem_wdata !== 8'hA7) begin
      n_err++;
      $display("FAIL writeback: seen=%b wren=%b addr=%h wdata=%h expected 1 1 05 a7",
               seen, bus.mem_wren, bus.mem_addr, bus.mem_wdata);
    end
    mem_ack_now(8'h00);
    n_vec++;
    if (bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL wb_req_drop: mem_req=%b expected 0", bus.mem_req);
    end
    wait_mem(seen);
    n_vec++;
    if (!seen || bus.mem_wren !== 1'b0 || bus.mem_addr !== 8'h0D) begin
      n_err++;
      $display("FAIL fill_0d: seen=%b wren=%b addr=%h expected 1 0 0d", seen, bus.mem_wren, bus.mem_addr);
    end
    mem_ack_now(8'h6E);
    wait_done(seen, edges, hit, rd, saw_mem);
    n_vec++;
    if (!seen || hit !== 1'b0 || rd !== 8'h6E) begin
      n_err++;
      $display("FAIL done_0d: seen=%b hit=%b rdata=%h expected 1 0 6e", seen, hit, rd);
    end
  endtask

  task automatic test_stats();
`ifdef CACHE_STATS_EN
    n_vec++;
    if (hit_count !== 16'd3 || miss_count !== 16'd3) begin
      n_err++;
      $display("FAIL stats: hit=%0d miss=%0d expected 3 3", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_slow_ack();
    logic seen;
    logic [7:0] rd;
    int dones, reqs;
    // Set 1 holds 0x0D (way0) and 0x09 (way1, LRU, clean): clean fill of 0x11.
    drive_req(8'h11, 1'b0, 8'h00);
    wait_mem(seen);
    n_vec++;
    if (!seen || bus.mem_addr !== 8'h11 || bus.mem_wren !== 1'b0) begin
      n_err++;
      $display("FAIL slow_fill_req: seen=%b addr=%h wren=%b expected 1 11 0", seen, bus.mem_addr, bus.mem_wren);
    end
    for (int i = 0; i < 5; i++) begin
      bus.cpu_req  = (i % 2 == 0);
      bus.cpu_addr = 8'h22;
      @(negedge clock);
      n_vec++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h11 || bus.cpu_ready !== 1'b0 || bus.cpu_done !== 1'b0) begin
        n_err++;
        $display("FAIL slow_hold[%0d]: req=%b addr=%h ready=%b done=%b expected 1 11 0 0",
                 i, bus.mem_req, bus.mem_addr, bus.cpu_ready, bus.cpu_done);
      end
    end
    bus.cpu_req = 1'b0;
    mem_ack_now(8'h99);
    dones = 0; reqs = 0; rd = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (bus.cpu_done) begin
        dones++;
        rd = bus.cpu_rdata;
      end
      if (bus.mem_req) reqs++;
      @(negedge clock);
    end
    n_vec++;
    if (dones !== 1 || reqs !== 0 || rd !== 8'h99 || bus.cpu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL slow_done: dones=%0d reqs=%0d rdata=%h ready=%b expected 1 0 99 1",
               dones, reqs, rd, bus.cpu_ready);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic seen, hit, saw_mem;
    logic [7:0] rd;
    int edges;
    drive_req(8'h05, 1'b0, 8'h00);
    wait_mem(seen);
    n_vec++;
    if (!seen || bus.mem_addr !== 8'h05 || bus.mem_wren !== 1'b0) begin
      n_err++;
      $display("FAIL rst_fill_req: seen=%b addr=%h wren=%b expected 1 05 0", seen, bus.mem_addr, bus.mem_wren);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async_req: mem_req=%b expected 0", bus.mem_req);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_vec++;
    if (bus.cpu_ready !== 1'b1 || bus.cpu_done !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: ready=%b done=%b req=%b expected 1 0 0", bus.cpu_ready, bus.cpu_done, bus.mem_req);
    end
`ifdef CACHE_STATS_EN
    n_vec++;
    if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
      n_err++;
      $display("FAIL rst_stats: hit=%0d miss=%0d expected 0 0", hit_count, miss_count);
    end
`endif
    drive_req(8'h05, 1'b0, 8'h00);
    wait_mem(seen);
    n_vec++;
    if (!seen || bus.mem_wren !== 1'b0 || bus.mem_addr !== 8'h05) begin
      n_err++;
      $display("FAIL rst_remiss: seen=%b wren=%b addr=%h expected 1 0 05", seen, bus.mem_wren, bus.mem_addr);
    end
    mem_ack_now(8'hA7);
    wait_done(seen, edges, hit, rd, saw_mem);
    n_vec++;
    if (!seen || hit !== 1'b0 || rd !== 8'hA7) begin
      n_err++;
      $display("FAIL rst_remiss_done: seen=%b hit=%b rdata=%h expected 1 0 a7", seen, hit, rd);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset_n       = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_wren  = 1'b0;
    bus.cpu_addr  = 8'h00;
    bus.cpu_wdata = 8'h00;
    bus.mem_rdata = 8'h00;
    bus.mem_ack   = 1'b0;
    test_reset();
    test_read_miss_fill();
    test_read_hit();
    test_write_hit();
    test_writeback();
    test_stats();
    test_slow_ack();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_2way_ctrl.md
Name: cache_2way_ctrl

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate cache controller with LRU replacement.
- Sits between the board-level user port (switch/key driven) and the backing RAM.
- Replaces the fixed-size, single-cycle cache path with a variable-latency req/ack memory handshake.
- The user side gets explicit ready/done/hit status.

Parameters:
- ADDR_W, 8, address width in words.
- DATA_W, 8, data word width; one word per line.
- SETS, 4, number of sets; power of two, >= 2; INDEX_W = clog2(SETS), TAG_W = ADDR_W - INDEX_W.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request strobe; sampled only while cpu_ready=1.
- cpu_wren  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address; index = cpu_addr[INDEX_W-1:0], tag = upper bits.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  controller idle, can accept a request.
- cpu_done  out  1  one-cycle pulse: access complete.
- cpu_hit  out  1  valid with cpu_done: 1 = hit, 0 = miss.
- cpu_rdata  out  DATA_W  read data; valid with cpu_done, held until the next done.
- mem_req  out  1  backing-memory request, held until mem_ack.
- mem_wren  out  1  1 = writeback, 0 = fill.
- mem_addr  out  ADDR_W  backing-memory address.
- mem_wdata  out  DATA_W  writeback data.
- mem_rdata  in  DATA_W  fill data; valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion from the backing memory.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - state=IDLE, cpu_ready=1, cpu_done=0, cpu_hit=0, cpu_rdata=0.
  - mem_req=0, mem_wren=0, mem_addr=0, mem_wdata=0.
  - All valid, dirty and LRU bits = 0.
  - Tag and data arrays are not reset.
  - Reset mid-operation aborts the access and silently discards dirty data.
- State machine: IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
- IDLE:
  - cpu_ready=1.
  - When cpu_req=1, capture addr/wren/wdata at the edge and go to LOOKUP.
  - cpu_ready=0 in every other state; cpu_req is ignored there.
- LOOKUP:
  - Compare the tag against both valid ways.
  - On hit: read returns the line; write updates the line and sets dirty. LRU is set to point at the other way. cpu_done=1 and cpu_hit=1 the next cycle, then IDLE.
  - Hit latency: done is visible 2 cycles after the accepting edge.
- Miss victim selection:
  - First invalid way, way 0 preferred.
  - Otherwise the LRU way.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL.
- WRITEBACK:
  - mem_req=1, mem_wren=1, mem_addr={victim tag, index}, mem_wdata=victim data.
  - Outputs stay stable until mem_ack, then FILL.
- FILL:
  - mem_req=1, mem_wren=0, mem_addr=captured cpu_addr.
  - On mem_ack: write mem_rdata into the victim, set valid=1, dirty=0, tag=captured tag, then RESPOND.
- RESPOND:
  - A write merges cpu_wdata and sets dirty=1.
  - Update LRU.
  - cpu_done=1, cpu_hit=0 next cycle, then IDLE.
- Handshake rules:
  - mem_req deasserts the cycle after mem_ack.
  - An ack arriving while mem_req=0 is ignored.
  - Memory latency is unbounded; there is no timeout.
- Same-set back-to-back requests always see the state produced by the previous access.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_count and miss_count, 16 bits each.
  - Incremented on every cpu_done with cpu_hit=1 or 0 respectively.
  - Both saturate at 0xFFFF.
  - Both cleared by reset_n.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan (ADDR_W=8, DATA_W=8, SETS=4):
- Reset, then read 0x05; memory acks fill addr 0x05 with 0x3C. Required: no writeback, cpu_done with hit=0, rdata=0x3C. Read 0x05 again: hit=1, rdata=0x3C, done 2 cycles after acceptance, mem_req never asserted.
- Write 0x05=0xA7 (hit), then read 0x05. Required: no mem activity, rdata=0xA7.
- Read 0x09 (fills way1), read 0x0D (set 1 full, LRU=way0 holds dirty 0x05). Required: WRITEBACK mem_addr=0x05, mem_wdata=0xA7, mem_wren=1, then FILL mem_addr=0x0D.
- mem_ack delayed 5 cycles and cpu_req toggled while busy. Required: mem_req/mem_addr stable for all 5 cycles, cpu_ready=0, extra requests ignored, exactly one cpu_done.
- reset_n pulsed low during FILL. Required: mem_req=0 immediately, cpu_ready=1 after release, read 0x05 misses again.
- CACHE_STATS_EN defined, run scenarios 1-3. Required: hit_count=3 (two reads + write of 0x05), miss_count=3 (0x05, 0x09, 0x0D).
